// File: rtl/pipe_hazard_ctrl.sv
// Central hazard controller: in-flight writer scoreboard, load-use/branch/memory-wait control, forwarding selects.
// Optional feature macro: HAZ_FWD_EN (forwarding enabled; only load-use at entry 1 stalls).
module pipe_hazard_ctrl #(
  parameter int NUM_REGS    = 32,
  parameter int PIPE_DEPTH  = 3,
  parameter int BR_STAGE    = 2,
  parameter int MEM_STAGE   = 2,
  parameter int MEM_TIMEOUT = 255,
  localparam int IDX_W = $clog2(NUM_REGS),
  localparam int FWD_W = $clog2(PIPE_DEPTH + 1),
  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  logic [IDX_W-1:0]      id_rs1_idx,
  input  logic                  id_rs1_used,
  input  logic [IDX_W-1:0]      id_rs2_idx,
  input  logic                  id_rs2_used,
  input  logic [IDX_W-1:0]      id_rd_idx,
  input  logic                  id_reg_wr,
  input  logic                  id_is_load,
  input  logic                  br_taken,
  input  logic                  dmem_req,
  input  logic                  dmem_ready,
  output logic [PIPE_DEPTH:0]   stage_en,
  output logic [PIPE_DEPTH:0]   stage_flush,
  output logic [FWD_W-1:0]      fwd_a_sel,
  output logic [FWD_W-1:0]      fwd_b_sel,
  output logic                  mem_timeout,
  output logic [31:0]           stall_cycles
);

  typedef enum logic [0:0] {RUN = 1'b0, MEM_WAIT = 1'b1} state_e;

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] rd;
    logic             wr;
    logic             ld;
  } sb_entry_t;

  localparam logic [PIPE_DEPTH:0] BR_MASK = {{(PIPE_DEPTH - BR_STAGE){1'b0}}, {(BR_STAGE + 1){1'b1}}};

  if (BR_STAGE < 1 || BR_STAGE >= PIPE_DEPTH || MEM_STAGE < 1 || MEM_STAGE >= PIPE_DEPTH) begin : g_bad_cfg
    $error("pipe_hazard_ctrl: BR_STAGE and MEM_STAGE must lie in 1..PIPE_DEPTH-1");
  end

  state_e              state_r, state_nx_s;
  logic [CNT_W-1:0]    cnt_r, cnt_nx_s;
  logic                mem_timeout_r, tmo_set_s;
  logic [31:0]         stall_r;
  sb_entry_t           sb_r     [1:PIPE_DEPTH];
  sb_entry_t           sb_src_s [1:PIPE_DEPTH];
  logic [PIPE_DEPTH:1] match_a_s, match_b_s;
  logic [FWD_W-1:0]    win_a_s, win_b_s;
  logic                hazard_s, freeze_s;
  logic [PIPE_DEPTH:0] en_s, flush_s;

  // Per-entry source operand matches against in-flight writers (x0 never matches)
  always_comb begin
    match_a_s = '0;
    match_b_s = '0;
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      match_a_s[k] = id_valid && id_rs1_used && sb_r[k].valid && sb_r[k].wr &&
                     (sb_r[k].rd != '0) && (sb_r[k].rd == id_rs1_idx);
      match_b_s[k] = id_valid && id_rs2_used && sb_r[k].valid && sb_r[k].wr &&
                     (sb_r[k].rd != '0) && (sb_r[k].rd == id_rs2_idx);
    end
  end

`ifdef HAZ_FWD_EN
  // Youngest matching entry wins; only a load still in entry 1 cannot be forwarded
  always_comb begin
    win_a_s = '0;
    win_b_s = '0;
    for (int k = PIPE_DEPTH; k >= 1; k--) begin
      win_a_s = match_a_s[k] ? FWD_W'(k) : win_a_s;
      win_b_s = match_b_s[k] ? FWD_W'(k) : win_b_s;
    end
    hazard_s = ((win_a_s == FWD_W'(1)) || (win_b_s == FWD_W'(1))) && sb_r[1].ld;
  end
`else
  logic unused_s;

  // Without forwarding every writer short of the write-through stage blocks ID
  always_comb begin
    win_a_s  = '0;
    win_b_s  = '0;
    hazard_s = (|match_a_s[PIPE_DEPTH-1:1]) || (|match_b_s[PIPE_DEPTH-1:1]);
    unused_s = match_a_s[PIPE_DEPTH] ^ match_b_s[PIPE_DEPTH];
    for (int k = 1; k <= PIPE_DEPTH; k++) begin
      unused_s = unused_s ^ sb_r[k].ld;
    end
  end
`endif

  // Memory-wait FSM next state plus enable/flush decode; freeze outranks branch outranks stall
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    freeze_s   = 1'b0;
    en_s       = '1;
    flush_s    = '0;
    case (state_r)
      RUN: begin
        if (dmem_req && !dmem_ready) begin
          state_nx_s = MEM_WAIT;
          freeze_s   = 1'b1;
        end else begin
          state_nx_s = RUN;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_nx_s = RUN;
          cnt_nx_s   = '0;
        end else begin
          freeze_s = 1'b1;
          cnt_nx_s = (cnt_r == CNT_W'(MEM_TIMEOUT)) ? cnt_r : cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_nx_s = RUN;
        cnt_nx_s   = '0;
      end
    endcase
    tmo_set_s = (state_r == MEM_WAIT) && !dmem_ready && (cnt_nx_s == CNT_W'(MEM_TIMEOUT));
    if (freeze_s) begin
      en_s = '0;
    end else if (br_taken) begin
      flush_s = BR_MASK;
    end else if (hazard_s) begin
      en_s[0]    = 1'b0;
      flush_s[1] = 1'b1;
    end else begin
      en_s    = '1;
      flush_s = '0;
    end
  end

  // Scoreboard source: entry 1 from ID, later entries from their predecessor
  always_comb begin
    sb_src_s[1] = {id_valid, id_rd_idx, id_reg_wr, id_is_load};
    for (int k = 2; k <= PIPE_DEPTH; k++) begin
      sb_src_s[k] = sb_r[k-1];
    end
  end

  // Scoreboard shift with bubble insertion on flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 1; k <= PIPE_DEPTH; k++) sb_r[k] <= '0;
    end else begin
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        if (en_s[k]) sb_r[k] <= flush_s[k] ? '0 : sb_src_s[k];
      end
    end
  end

  // FSM state, wait counter, sticky timeout and stall statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= RUN;
      cnt_r         <= '0;
      mem_timeout_r <= 1'b0;
      stall_r       <= 32'd0;
    end else begin
      state_r <= state_nx_s;
      cnt_r   <= cnt_nx_s;
      if (tmo_set_s) mem_timeout_r <= 1'b1;
      if (!en_s[0]) stall_r <= stall_r + 32'd1;
    end
  end

  assign stage_en     = rst ? '0 : en_s;
  assign stage_flush  = rst ? '1 : flush_s;
  assign fwd_a_sel    = rst ? '0 : win_a_s;
  assign fwd_b_sel    = rst ? '0 : win_b_s;
  assign mem_timeout  = mem_timeout_r;
  assign stall_cycles = stall_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default parameters, either HAZ_FWD_EN setting).
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_rs1_used, id_rs2_used, id_reg_wr, id_is_load;
  logic [4:0]  id_rs1_idx, id_rs2_idx, id_rd_idx;
  logic        br_taken, dmem_req, dmem_ready;
  logic [3:0]  stage_en, stage_flush;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        mem_timeout;
  logic [31:0] stall_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stall = 0;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_idx(id_rs1_idx), .id_rs1_used(id_rs1_used),
    .id_rs2_idx(id_rs2_idx), .id_rs2_used(id_rs2_used), .id_rd_idx(id_rd_idx),
    .id_reg_wr(id_reg_wr), .id_is_load(id_is_load), .br_taken(br_taken),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .stage_en(stage_en), .stage_flush(stage_flush),
    .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
    .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic u1,
                        input logic [4:0] rs2, input logic u2,
                        input logic [4:0] rd, input logic wr, input logic ld);
    id_valid = v; id_rs1_idx = rs1; id_rs1_used = u1;
    id_rs2_idx = rs2; id_rs2_used = u2;
    id_rd_idx = rd; id_reg_wr = wr; id_is_load = ld;
  endtask

  task automatic idle(input int n);
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1'b1; br_taken = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
    set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_en",    stage_en,     32'h0);
    check_eq("rst_flush", stage_flush,  32'hF);
    check_eq("rst_fwda",  fwd_a_sel,    32'h0);
    check_eq("rst_tmo",   mem_timeout,  32'h0);
    check_eq("rst_stall", stall_cycles, 32'h0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check_eq("idle_en",    stage_en,    32'hF);
    check_eq("idle_flush", stage_flush, 32'h0);

    // add x5 in entry 1, then ID reads rs1=x5
    tick(); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0);
    tick(); set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd6, 1'b1, 1'b0);
    @(negedge clk);
`ifdef HAZ_FWD_EN
    check_eq("t1_fwda", fwd_a_sel, 32'h1);
    check_eq("t1_en",   stage_en,  32'hF);
`else
    check_eq("t1_en1",    stage_en,    32'hE);
    check_eq("t1_flush1", stage_flush, 32'h2);
    check_eq("t1_fwda",   fwd_a_sel,   32'h0);
    tick(); @(negedge clk);
    check_eq("t1_en2", stage_en, 32'hE);
    tick(); @(negedge clk);
    check_eq("t1_en3", stage_en, 32'hF);
    exp_stall += 2;
`endif
    check_eq("t1_stall", stall_cycles, exp_stall);
    tick(); idle(3);

    // lw x7 in entry 1, then ID reads rs2=x7
    set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick(); set_id(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("t2_en1",    stage_en,    32'hE);
    check_eq("t2_flush1", stage_flush, 32'h2);
    tick(); @(negedge clk);
`ifdef HAZ_FWD_EN
    check_eq("t2_fwdb", fwd_b_sel, 32'h2);
    check_eq("t2_en2",  stage_en,  32'hF);
    exp_stall += 1;
`else
    check_eq("t2_en2", stage_en, 32'hE);
    tick(); @(negedge clk);
    check_eq("t2_en3", stage_en,  32'hF);
    check_eq("t2_fwdb", fwd_b_sel, 32'h0);
    exp_stall += 2;
`endif
    tick(); idle(3);
    @(negedge clk);
    check_eq("t2_stall", stall_cycles, exp_stall);

    // branch overrides a simultaneous load-use stall
    tick(); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    tick(); set_id(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0); br_taken = 1'b1;
    @(negedge clk);
    check_eq("t3_flush", stage_flush, 32'h7);
    check_eq("t3_en",    stage_en,    32'hF);
    tick(); br_taken = 1'b0; idle(3);
    @(negedge clk);
    check_eq("t3_stall", stall_cycles, exp_stall);

    // x0 writer never matches
    tick(); set_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    tick(); set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
    @(negedge clk);
    check_eq("t6_fwda", fwd_a_sel, 32'h0);
    check_eq("t6_en",   stage_en,  32'hF);
    tick(); idle(3);

    // memory wait: ready low 4 cycles
    dmem_req = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check_eq("t4_freeze_en",    stage_en,    32'h0);
      check_eq("t4_freeze_flush", stage_flush, 32'h0);
      tick();
    end
    dmem_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_resume_en", stage_en, 32'hF);
    tick(); dmem_req = 1'b0; dmem_ready = 1'b0;
    exp_stall += 4;
    @(negedge clk);
    check_eq("t4_stall", stall_cycles, exp_stall);
    check_eq("t4_tmo",   mem_timeout,  32'h0);

    // memory timeout: ready low 300 cycles
    tick(); dmem_req = 1'b1;
    repeat (255) tick();
    @(negedge clk);
    check_eq("t5_tmo_254", mem_timeout, 32'h0);
    tick(); @(negedge clk);
    check_eq("t5_tmo_255", mem_timeout, 32'h1);
    repeat (44) tick();
    dmem_ready = 1'b1;
    @(negedge clk);
    check_eq("t5_resume_en", stage_en, 32'hF);
    tick(); dmem_req = 1'b0; dmem_ready = 1'b0;
    exp_stall += 300;
    @(negedge clk);
    check_eq("t5_stall",   stall_cycles, exp_stall);
    check_eq("t5_tmo_hold", mem_timeout, 32'h1);

    // reset asserted mid-wait
    tick(); dmem_req = 1'b1;
    repeat (3) tick();
    rst = 1'b1;
    #1;
    check_eq("t6_rst_en",    stage_en,     32'h0);
    check_eq("t6_rst_flush", stage_flush,  32'hF);
    check_eq("t6_rst_fwdb",  fwd_b_sel,    32'h0);
    check_eq("t6_rst_tmo",   mem_timeout,  32'h0);
    check_eq("t6_rst_stall", stall_cycles, 32'h0);
    dmem_req = 1'b0;
    tick(); rst = 1'b0;
    @(negedge clk);
    check_eq("t6_run_en", stage_en, 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
